// File: rtl/mem_data_ctrl.sv
// MEM-stage data bus sequencer: issues one load/store per access on an
// SRAM-like req/addr_ok/data_ok bus, stalls the pipeline while the access is
// outstanding, returns load data and drains responses of flushed instructions.
module mem_data_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_data_en,
  input  logic [3:0]  ex_data_ren,
  input  logic [3:0]  ex_data_wen,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic [31:0] mem_rdata,
  output logic        rdata_valid,
  output logic        bus_err
);

  localparam int             CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CANCEL} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          cancel_q;
  logic          req_q, wr_q, rvld_q, berr_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;

  logic [3:0]    strb_all;
  logic [2:0]    pcnt;
  logic [1:0]    size_d;
  logic          accept, progress, tmo, cancel_now;

  // Access size from the number of active byte lanes.
  always_comb begin
    strb_all = ex_data_ren | ex_data_wen;
    pcnt     = {2'b0, strb_all[0]} + {2'b0, strb_all[1]}
             + {2'b0, strb_all[2]} + {2'b0, strb_all[3]};
    case (pcnt)
      3'd2:       size_d = 2'd1;
      3'd3, 3'd4: size_d = 2'd2;
      default:    size_d = 2'd0;
    endcase
  end

  // A handshake in the last allowed cycle wins over the timeout, so a
  // completing access never also reports bus_err.
  assign accept     = (state_q == IDLE) & ex_data_en & ~flush;
  assign progress   = ((state_q == REQ) & data_addr_ok)
                    | (((state_q == WAIT) | (state_q == CANCEL)) & data_data_ok);
  assign tmo        = (state_q != IDLE) & (cnt_q == LAST) & ~progress;
  assign cancel_now = cancel_q | flush;

  assign stall = resetn & ~tmo &
                 (accept | (state_q == REQ)
                  | (((state_q == WAIT) | (state_q == CANCEL)) & ~data_data_ok));

  // Access FSM with registered bus-side and pipeline-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          cancel_q <= 1'b0;
          if (accept) begin
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            wstrb_q <= ex_data_wen;
            wr_q    <= |ex_data_wen;
            size_q  <= size_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (data_data_ok) begin
              state_q <= IDLE;
              if (!wr_q && !cancel_now) begin
                rdata_q <= data_rdata;
                rvld_q  <= 1'b1;
              end
            end else begin
              state_q <= cancel_now ? CANCEL : WAIT;
            end
          end else if (tmo) begin
            req_q   <= 1'b0;
            berr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            cancel_q <= cancel_now;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!wr_q) begin
              rdata_q <= data_rdata;
              rvld_q  <= 1'b1;
            end
          end else if (tmo) begin
            berr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (flush) begin
            cnt_q   <= '0;
            state_q <= CANCEL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CANCEL: begin
          if (data_data_ok) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (tmo) begin
            berr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_req    = req_q;
  assign data_wr     = wr_q;
  assign data_size   = size_q;
  assign data_addr   = addr_q;
  assign data_wstrb  = wstrb_q;
  assign data_wdata  = wdata_q;
  assign mem_rdata   = rdata_q;
  assign rdata_valid = rvld_q;
  assign bus_err     = berr_q;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed bench for mem_data_ctrl with a load-data scoreboard.
module tb_mem_data_ctrl;

  logic        clk, resetn;
  logic        ex_data_en, flush;
  logic [3:0]  ex_data_ren, ex_data_wen;
  logic [31:0] ex_addr, ex_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        stall, rdata_valid, bus_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  mem_data_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .ex_data_en(ex_data_en), .ex_data_ren(ex_data_ren), .ex_data_wen(ex_data_wen),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall(stall), .mem_rdata(mem_rdata), .rdata_valid(rdata_valid), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rdata_valid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_unexpected_valid: observed mem_rdata %h expected no pulse", mem_rdata);
      end else begin
        chk("sb_mem_rdata", mem_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0; ex_data_en = 1'b1; flush = 1'b0;
    ex_data_ren = 4'hF; ex_data_wen = 4'h0; ex_addr = 32'h0; ex_wdata = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", data_req, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_addr", data_addr, 0);
    ex_data_en = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();

    // Byte load, immediate addr_ok+data_ok.
    ex_data_en = 1; ex_data_ren = 4'b1000; ex_data_wen = 0; ex_addr = 32'h1003;
    #1; chk("ld_accept_stall", stall, 1); chk("ld_accept_req", data_req, 0);
    step();
    ex_data_en = 0; ex_data_ren = 0;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hAB000000;
    exp_q.push_back(32'hAB000000);
    #1;
    chk("ld_req", data_req, 1); chk("ld_size", data_size, 0); chk("ld_wr", data_wr, 0);
    chk("ld_addr", data_addr, 32'h1003); chk("ld_req_stall", stall, 1);
    step();
    data_addr_ok = 0; data_data_ok = 0;
    #1;
    chk("ld_rvalid", rdata_valid, 1); chk("ld_mem_rdata", mem_rdata, 32'hAB000000);
    chk("ld_req_drop", data_req, 0); chk("ld_stall_done", stall, 0);
    step();
    chk("ld_rvalid_pulse", rdata_valid, 0);

    // Word store, addr_ok after 3 cycles, data_ok 2 cycles later.
    ex_data_en = 1; ex_data_wen = 4'hF; ex_addr = 32'h2000; ex_wdata = 32'hDEADBEEF;
    step();
    ex_data_en = 0; ex_data_wen = 0;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      #1;
      chk("st_req_held", data_req, 1); chk("st_stall", stall, 1);
      if (i == 0) begin
        chk("st_wr", data_wr, 1); chk("st_size", data_size, 2);
        chk("st_wstrb", data_wstrb, 4'hF); chk("st_wdata", data_wdata, 32'hDEADBEEF);
      end
      step();
    end
    data_addr_ok = 0;
    #1; chk("st_wait_req", data_req, 0); chk("st_wait_stall", stall, 1);
    step();
    data_data_ok = 1; data_rdata = 32'h0BADF00D;
    #1; chk("st_dok_stall", stall, 0);
    step();
    data_data_ok = 0;
    #1; chk("st_no_rvalid", rdata_valid, 0); chk("st_mem_rdata_kept", mem_rdata, 32'hAB000000);

    // Half load, flush in WAIT -> CANCEL drains the response.
    ex_data_en = 1; ex_data_ren = 4'b0011; ex_addr = 32'h3002;
    step();
    ex_data_en = 0; ex_data_ren = 0; data_addr_ok = 1;
    #1; chk("fw_size", data_size, 1);
    step();
    data_addr_ok = 0; flush = 1;
    #1; chk("fw_wait_stall", stall, 1);
    step();
    flush = 0;
    #1; chk("fw_cancel_stall", stall, 1); chk("fw_cancel_req", data_req, 0);
    step();
    data_data_ok = 1; data_rdata = 32'h12345678;
    #1; chk("fw_dok_stall", stall, 0);
    step();
    data_data_ok = 0;
    #1; chk("fw_no_rvalid", rdata_valid, 0); chk("fw_mem_rdata_kept", mem_rdata, 32'hAB000000);
    chk("fw_idle_stall", stall, 0);

    // Word load, flush during REQ: request held until addr_ok, then drained.
    ex_data_en = 1; ex_data_ren = 4'hF; ex_addr = 32'h4000;
    step();
    ex_data_en = 0; ex_data_ren = 0; flush = 1;
    #1; chk("fr_req_c1", data_req, 1);
    step();
    flush = 0;
    #1; chk("fr_req_c2", data_req, 1); chk("fr_stall_c2", stall, 1);
    step();
    data_addr_ok = 1;
    #1; chk("fr_req_c3", data_req, 1);
    step();
    data_addr_ok = 0;
    #1; chk("fr_cancel_req", data_req, 0); chk("fr_cancel_stall", stall, 1);
    step();
    data_data_ok = 1; data_rdata = 32'h55555555;
    #1; chk("fr_dok_stall", stall, 0);
    step();
    data_data_ok = 0;
    #1; chk("fr_no_rvalid", rdata_valid, 0); chk("fr_mem_rdata_kept", mem_rdata, 32'hAB000000);

    // addr_ok never arrives: bus_err after 4 REQ cycles.
    ex_data_en = 1; ex_data_ren = 4'hF; ex_addr = 32'h5000;
    step();
    ex_data_en = 0; ex_data_ren = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("to_req", data_req, 1); chk("to_no_berr", bus_err, 0);
      step();
    end
    #1;
    chk("to_berr", bus_err, 1); chk("to_req_drop", data_req, 0);
    chk("to_stall", stall, 0); chk("to_no_rvalid", rdata_valid, 0);
    step();
    chk("to_berr_pulse", bus_err, 0);

    // Reset asserted mid-WAIT, late data_ok afterwards is ignored.
    ex_data_en = 1; ex_data_ren = 4'hF; ex_addr = 32'h6000;
    step();
    ex_data_en = 0; ex_data_ren = 0; data_addr_ok = 1;
    step();
    data_addr_ok = 0;
    #1; chk("rw_wait_stall", stall, 1);
    resetn = 0;
    #1;
    chk("rw_stall", stall, 0); chk("rw_mem_rdata", mem_rdata, 0);
    chk("rw_addr", data_addr, 0); chk("rw_req", data_req, 0); chk("rw_size", data_size, 0);
    step();
    resetn = 1;
    step();
    data_data_ok = 1; data_rdata = 32'h77777777;
    step();
    data_data_ok = 0;
    #1;
    chk("rw_late_rvalid", rdata_valid, 0); chk("rw_late_mem_rdata", mem_rdata, 0);
    chk("rw_idle_stall", stall, 0); chk("rw_idle_req", data_req, 0);

    // Fresh byte load after reset recovery.
    ex_data_en = 1; ex_data_ren = 4'b0100; ex_addr = 32'h7002;
    step();
    ex_data_en = 0; ex_data_ren = 0;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h00CD0000;
    exp_q.push_back(32'h00CD0000);
    #1; chk("pr_size", data_size, 0); chk("pr_addr", data_addr, 32'h7002);
    step();
    data_addr_ok = 0; data_data_ok = 0;
    #1; chk("pr_rvalid", rdata_valid, 1);
    step(); step();

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
